alu_cmd_pipe: RTL
=================

Name: alu_cmd_pipe

Overview:
Command front-end and result back-end for the 4-bit ALU (ArithmeticLogicUnit).
- Buffers incoming operation commands in a small FIFO.
- Registers operands/opcode into an issue stage that drives the ALU, then captures the ALU output into a result register with valid/ready handshake.
- Supports accumulator chaining: operand a can be taken from the previous result.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of 2, at least 2
CNT_W, 8, width of completed-operation counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept (not full)
cmd_sel  input  4  ALU opcode
cmd_a  input  4  operand a
cmd_b  input  4  operand b
cmd_use_acc  input  1  replace operand a with accumulator at issue
alu_a  output  4  to ALU a (registered)
alu_b  output  4  to ALU b (registered)
alu_sel  output  4  to ALU sel (registered)
alu_y  input  8  from ALU y, combinational function of alu_a/alu_b/alu_sel
res_valid  output  1  result register holds data
res_ready  input  1  consumer accepts result
res_data  output  8  captured signed result
res_zero  output  1  res_data == 0
res_neg  output  1  res_data[7]
op_count  output  CNT_W  completed result handshakes, wraps

Behaviour:
- Reset (async, rst_n low): FIFO empty, cmd_ready=1, s1_valid=0, alu_a/alu_b/alu_sel=0, res_valid=0, res_data=0, res_zero=0, res_neg=0, acc=0, op_count=0. Reset mid-operation discards all queued and in-flight commands.
- Push: cmd_valid && cmd_ready writes {sel,a,b,use_acc} at the tail.
- cmd_ready = !full. There is no push-through when full, even if a pop occurs the same cycle.
- Pipeline advance, evaluated each cycle:
  - s2_load = s1_valid && (!res_valid || res_ready)
  - s1_free = !s1_valid || s2_load
  - pop = !empty && s1_free
- Issue (pop): alu_sel<=head.sel, alu_b<=head.b, s1_valid<=1.
  - alu_a <= head.a if !head.use_acc.
  - If head.use_acc and s1_valid, alu_a <= alu_y[3:0] (forward from the in-flight op).
  - If head.use_acc and !s1_valid, alu_a <= acc.
- If s1_free && empty: s1_valid<=0. alu_* hold their last values.
- Capture (s2_load):
  - res_data<=alu_y, res_valid<=1, acc<=alu_y[3:0].
  - res_zero and res_neg are registered from alu_y.
- Drain: res_valid && res_ready && !s2_load -> res_valid<=0 (res_data holds).
- op_count increments on each res_valid && res_ready cycle; wraps from 2^CNT_W-1 to 0.
- Latency: command accepted at edge N reaches S1 at N+1 and res_valid at N+2 (empty pipe, res_ready=1). Sustained throughput is 1 op/cycle.
- Backpressure: res_ready=0 with res_valid=1 holds S1 and the FIFO. The FIFO fills and cmd_ready drops when DEPTH entries are stored.
- Ordering is strict FIFO. No command is dropped or duplicated.
- ALU semantics, for bench prediction: result is 4-bit, sign-extended to 8 bits on alu_y.

Test Plan:
- Single add (sel=0110, a=3, b=4), res_ready=1: alu_sel=0110 one cycle after accept; res_data=8'h07 two cycles after; res_zero=0, res_neg=0; op_count=1.
- Overflow/sign (sel=0110, a=7, b=1): res_data=8'hF8, res_neg=1. Logic op sel=1000, a=0: res_data=8'hFF.
- Chained back-to-back, forward path:
  - Commands: (0110, a=2, b=3) then (0110, use_acc=1, a=9, b=1).
  - Results in order: 8'h05 then 8'h06. The second op's alu_a=5, not 9.
- Chained with gap (acc path):
  - Commands: (0111, a=5, b=5) -> 8'h00, res_zero=1.
  - Idle 3 cycles.
  - Command (0000, use_acc=1) -> alu_a=0, res_data=8'h01.
- Backpressure/full, DEPTH=4:
  - Hold res_ready=0 and push 6 commands: res_valid=1, S1 occupied, 4 in FIFO, cmd_ready=0.
  - Release res_ready=1: all 6 results emerge in order on consecutive cycles; op_count=6.
- Reset mid-stream:
  - Assert rst_n=0 asynchronously with 3 commands queued and res_valid=1.
  - Outputs go to reset values immediately. After release, the next command produces the only result.

Source files
------------

// File: rtl/alu_cmd_pipe_if.sv
// Bundle of command, ALU and result signals for the ALU command pipe.
// slave is the pipe's view; master is the environment's view (command
// source, ALU and result consumer).
interface alu_cmd_pipe_if #(
   parameter int CNT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_sel;
   logic [3:0]       cmd_a;
   logic [3:0]       cmd_b;
   logic             cmd_use_acc;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic [3:0]       alu_sel;
   logic [7:0]       alu_y;
   logic             res_valid;
   logic             res_ready;
   logic [7:0]       res_data;
   logic             res_zero;
   logic             res_neg;
   logic [CNT_W-1:0] op_count;

   modport slave (
      input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc, alu_y, res_ready,
      output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_zero,
             res_neg, op_count
   );

   modport master (
      output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc, alu_y, res_ready,
      input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_zero,
             res_neg, op_count
   );
endinterface

// File: rtl/alu_cmd_pipe.sv
// Command FIFO, issue stage and result register around an external 4-bit ALU.
// Operand a can be replaced by the previous result (accumulator chaining),
// forwarded straight from the ALU when the producing op is still in flight.
module alu_cmd_pipe #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input logic          clk,
   input logic          rst_n,
   alu_cmd_pipe_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [3:0] sel;
      logic [3:0] a;
      logic [3:0] b;
      logic       use_acc;
   } cmd_t;

   cmd_t             r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;

   logic             r_s1_valid;
   logic [3:0]       r_alu_a;
   logic [3:0]       r_alu_b;
   logic [3:0]       r_alu_sel;

   logic             r_res_valid;
   logic [7:0]       r_res_data;
   logic             r_res_zero;
   logic             r_res_neg;
   logic [3:0]       r_acc;
   logic [CNT_W-1:0] r_op_count;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_s2_load;
   logic             w_s1_free;
   logic             w_res_hs;
   cmd_t             w_head;
   cmd_t             w_wr_entry;

   // Extra pointer bit tells full from empty when the index bits match.
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push     = bus.cmd_valid && !w_full;
   assign w_s2_load  = r_s1_valid && (!r_res_valid || bus.res_ready);
   assign w_s1_free  = !r_s1_valid || w_s2_load;
   assign w_pop      = !w_empty && w_s1_free;
   assign w_res_hs   = r_res_valid && bus.res_ready;
   assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
   assign w_wr_entry = '{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b,
                         use_acc: bus.cmd_use_acc};

   // Command storage write.
   // NOTE: the FIFO array is deliberately not reset; the pointers alone say
   // which entries are live, and leaving the array out of reset keeps it RAM-mappable.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
      end
   end

   // FIFO pointers; full blocks push even when a pop happens the same cycle.
   // NOTE: all state updates use <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   // Issue stage: load ALU operands from the FIFO head, resolving accumulator use.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_sel  <= '0;
      end else if (w_pop) begin
         r_s1_valid <= 1'b1;
         r_alu_sel  <= w_head.sel;
         r_alu_b    <= w_head.b;
         if (!w_head.use_acc) begin
            r_alu_a <= w_head.a;
         end else if (r_s1_valid) begin
            // Producer is being captured this same edge; take its result directly.
            r_alu_a <= bus.alu_y[3:0];
         end else begin
            r_alu_a <= r_acc;
         end
      end else if (w_s1_free) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Result register and accumulator: capture ALU output, drain on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_zero  <= 1'b0;
         r_res_neg   <= 1'b0;
         r_acc       <= '0;
      end else if (w_s2_load) begin
         r_res_valid <= 1'b1;
         r_res_data  <= bus.alu_y;
         r_res_zero  <= (bus.alu_y == 8'h00);
         r_res_neg   <= bus.alu_y[7];
         r_acc       <= bus.alu_y[3:0];
      end else if (w_res_hs) begin
         r_res_valid <= 1'b0;
      end
   end

   // Completed-operation counter, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_count <= '0;
      end else if (w_res_hs) begin
         r_op_count <= r_op_count + CNT_W'(1);
      end
   end

   assign bus.cmd_ready = !w_full;
   assign bus.alu_a     = r_alu_a;
   assign bus.alu_b     = r_alu_b;
   assign bus.alu_sel   = r_alu_sel;
   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_res_data;
   assign bus.res_zero  = r_res_zero;
   assign bus.res_neg   = r_res_neg;
   assign bus.op_count  = r_op_count;

endmodule
